// File: rtl/fma16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fma16_pkg
// Brief    : Shared types, encodings and constants for the binary16 pack pipe.
// Revision : 1.0 - initial release
// ============================================================================
package fma16_pkg;

    typedef enum logic [1:0] {
        RZ  = 2'b00,
        RNE = 2'b01,
        RM  = 2'b10,
        RP  = 2'b11
    } rmode_e;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [15:0] QNAN16    = 16'h7E00;
    localparam logic [14:0] INF16     = 15'h7C00;
    localparam logic [14:0] MAXNORM16 = 15'h7BFF;
    localparam int          BIAS      = 15;

    // Stage-1 exponent is clamped at zero, so it is stored unsigned with headroom.
    localparam int                EXP_W   = 12;
    localparam logic [EXP_W-1:0]  EXP_OVF = EXP_W'(2 * BIAS + 1);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [10:0]       sig;
        logic              g;
        logic              r;
        logic              s;
        logic              nan;
        logic              inf;
        logic              inv;
        logic              zero;
        logic              tiny;
        rmode_e            rm;
    } s1_t;

    function automatic logic round_up(input rmode_e rm, input logic sign,
                                      input logic lsb, input logic g,
                                      input logic r, input logic s);
        case (rm)
            RNE:     return g & (r | s | lsb);
            RM:      return sign & (g | r | s);
            RP:      return ~sign & (g | r | s);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma16_pack_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : fma16_pack_pipe_if
// Brief    : Producer/consumer handshake and data bundle of the pack pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface fma16_pack_pipe_if #(
    parameter int SW = 22,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          Ss;
    logic [EW-1:0] Se;
    logic [SW-1:0] Sm;
    logic          sticky;
    logic          in_nan;
    logic          in_inf;
    logic          in_invalid;
    logic [1:0]    roundmode;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   result;
    logic [3:0]    flags;

    modport master (
        output in_valid, Ss, Se, Sm, sticky, in_nan, in_inf, in_invalid,
               roundmode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, Ss, Se, Sm, sticky, in_nan, in_inf, in_invalid,
               roundmode, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/fma16_lzc.sv
`default_nettype none
// ============================================================================
// Module   : fma16_lzc
// Brief    : Leading-zero counter; returns W when the input is all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module fma16_lzc #(
    parameter int W  = 22,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt = CW'(W - 1 - i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/fma16_pack_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fma16_pack_pipe
// Brief    : Two-stage normalize / round / pack to binary16 with valid-ready.
// Revision : 1.0 - initial release
// ============================================================================
module fma16_pack_pipe
    import fma16_pkg::*;
#(
    parameter int SW = 22,
    parameter int EW = 8
) (
    input  logic              clk,
    input  logic              reset,
    fma16_pack_pipe_if.slave  bus
);
    localparam int LZW = $clog2(SW + 1);
    localparam int SHW = $clog2(SW + 12);
    localparam int WW  = 2 * SW + 11;

    logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    s1_t  s1_q, s1_d, s1_in;
    logic [15:0] result_q, result_d, pk_result;
    logic [3:0]  flags_q, flags_d, pk_flags;
    logic        s2_adv, accept;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !reset && (!s1_valid_q || s2_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------- stage 1: normalize ----------------
    logic [LZW-1:0]    lz;
    logic [SW-1:0]     norm;
    logic signed [EW:0] e_norm;
    logic [EW+1:0]     sub_amt;
    logic [SHW-1:0]    sh;
    logic [WW-1:0]     wide;
    logic              sm_zero, subn, n_inc;

    fma16_lzc #(.W(SW), .CW(LZW)) u_lzc (.d(bus.Sm), .cnt(lz));

    always_comb begin
        sm_zero = (bus.Sm == '0);
        norm    = bus.Sm << lz;
        // Leading one at bit p gives E = Se + p - (SW-2) = Se + 1 - lz.
        e_norm  = sm_zero ? '0 : ({bus.Se[EW-1], bus.Se} + (EW+1)'(1) - (EW+1)'(lz));
        subn    = e_norm[EW] || (e_norm == '0);
        sub_amt = (EW+2)'(1) - {e_norm[EW], e_norm};
        sh      = '0;
        if (subn) begin
            sh = (sub_amt > (EW+2)'(SW + 11)) ? SHW'(SW + 11) : sub_amt[SHW-1:0];
        end
        wide  = {norm, {(SW + 11){1'b0}}} >> sh;
        // Tininess is judged on the normalized significand with unbounded exponent.
        n_inc = round_up(rmode_e'(bus.roundmode), bus.Ss, norm[SW-11], norm[SW-12],
                         norm[SW-13], (|norm[SW-14:0]) | bus.sticky);

        s1_in.sign = bus.Ss;
        s1_in.exp  = subn ? '0 : EXP_W'($unsigned(e_norm));
        s1_in.sig  = wide[WW-1 -: 11];
        s1_in.g    = wide[WW-12];
        s1_in.r    = wide[WW-13];
        s1_in.s    = (|wide[WW-14:0]) | bus.sticky;
        s1_in.nan  = bus.in_nan;
        s1_in.inf  = bus.in_inf;
        s1_in.inv  = bus.in_invalid;
        s1_in.zero = sm_zero && !bus.sticky;
        s1_in.tiny = e_norm[EW] || ((e_norm == '0) && !((&norm[SW-1:SW-11]) && n_inc));
        s1_in.rm   = rmode_e'(bus.roundmode);
    end

    // ---------------- stage 2: round and pack ----------------
    logic             inc, nx, ovf;
    logic [11:0]      sum;
    logic [EXP_W-1:0] exp_r;
    logic [9:0]       frac;

    always_comb begin
        inc   = round_up(s1_q.rm, s1_q.sign, s1_q.sig[0], s1_q.g, s1_q.r, s1_q.s);
        sum   = {1'b0, s1_q.sig} + {11'b0, inc};
        exp_r = s1_q.exp;
        frac  = sum[9:0];
        if (sum[11]) begin
            exp_r = s1_q.exp + EXP_W'(1);
            frac  = sum[10:1];
        end else if (sum[10] && (s1_q.exp == '0)) begin
            exp_r = EXP_W'(1);
        end
        nx  = s1_q.g | s1_q.r | s1_q.s;
        ovf = (exp_r >= EXP_OVF);

        pk_flags  = '0;
        pk_result = {s1_q.sign, exp_r[4:0], frac};
        if (s1_q.nan) begin
            pk_result         = QNAN16;
            pk_flags[FLAG_NV] = s1_q.inv;
        end else if (s1_q.inf) begin
            pk_result = {s1_q.sign, INF16};
        end else if (s1_q.zero) begin
            pk_result = {s1_q.sign, 15'h0000};
        end else if (ovf) begin
            pk_flags[FLAG_OF] = 1'b1;
            pk_flags[FLAG_NX] = 1'b1;
            case (s1_q.rm)
                RNE:     pk_result = {s1_q.sign, INF16};
                RM:      pk_result = {s1_q.sign, s1_q.sign ? INF16 : MAXNORM16};
                RP:      pk_result = {s1_q.sign, s1_q.sign ? MAXNORM16 : INF16};
                default: pk_result = {s1_q.sign, MAXNORM16};
            endcase
        end else begin
            pk_flags[FLAG_UF] = s1_q.tiny & nx;
            pk_flags[FLAG_NX] = nx;
        end
    end

    // ---------------- pipeline control ----------------
    always_comb begin
        s1_d        = accept ? s1_in : s1_q;
        s1_valid_d  = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (s2_adv && s1_valid_q) begin
            result_d = pk_result;
            flags_d  = pk_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            result_q    <= 16'h0000;
            flags_q     <= 4'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fma16_pack_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma16_pack_pipe
// Brief    : Vector table plus scoreboard bench for the binary16 pack pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fma16_pack_pipe;
    import fma16_pkg::*;

    localparam int SW = 22;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fma16_pack_pipe_if #(.SW(SW), .EW(EW)) bus ();
    fma16_pack_pipe #(.SW(SW), .EW(EW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string         name;
        logic          ss;
        logic [EW-1:0] se;
        logic [SW-1:0] sm;
        logic          st;
        logic          nan;
        logic          inf;
        logic          inv;
        logic [1:0]    rm;
        logic [15:0]   res;
        logic [3:0]    flg;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    vec_t vecs[$];
    vec_t stall_v[$];
    exp_t sb[$];
    exp_t cur_exp;
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input string name, input logic ss, input logic [EW-1:0] se,
                                input logic [SW-1:0] sm, input logic st, input logic nan,
                                input logic inf, input logic inv, input rmode_e rm,
                                input logic [15:0] res, input logic [3:0] flg);
        vec_t v;
        v.name = name; v.ss = ss; v.se = se; v.sm = sm; v.st = st;
        v.nan = nan; v.inf = inf; v.inv = inv; v.rm = rm; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard: push on acceptance, pop and compare on output transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h flags %h, required no output",
                             bus.result, bus.flags);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, 32'(bus.result), 32'(e.res));
                    check({e.name, " flags"}, 32'(bus.flags), 32'(e.flg));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        int n;
        bit acc;
        bus.Ss = v.ss; bus.Se = v.se; bus.Sm = v.sm; bus.sticky = v.st;
        bus.in_nan = v.nan; bus.in_inf = v.inf; bus.in_invalid = v.inv;
        bus.roundmode = v.rm;
        cur_exp.name = v.name; cur_exp.res = v.res; cur_exp.flg = v.flg;
        bus.in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout %s: in_ready stayed 0, required 1", v.name);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending items, required 0", sb.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs.push_back(mk("one",        0, 8'd15,  22'h100000, 0, 0, 0, 0, RNE, 16'h3C00, 4'h0));
        vecs.push_back(mk("tie_even",   0, 8'd15,  22'h100200, 0, 0, 0, 0, RNE, 16'h3C00, 4'h1));
        vecs.push_back(mk("tie_odd",    0, 8'd15,  22'h100600, 0, 0, 0, 0, RNE, 16'h3C02, 4'h1));
        vecs.push_back(mk("ovf_rne",    0, 8'd31,  22'h100000, 0, 0, 0, 0, RNE, 16'h7C00, 4'h5));
        vecs.push_back(mk("ovf_rz",     0, 8'd31,  22'h100000, 0, 0, 0, 0, RZ,  16'h7BFF, 4'h5));
        vecs.push_back(mk("ovf_rp_neg", 1, 8'd31,  22'h100000, 0, 0, 0, 0, RP,  16'hFBFF, 4'h5));
        vecs.push_back(mk("ovf_rm_neg", 1, 8'd31,  22'h100000, 0, 0, 0, 0, RM,  16'hFC00, 4'h5));
        vecs.push_back(mk("ovf_rm_pos", 0, 8'd31,  22'h100000, 0, 0, 0, 0, RM,  16'h7BFF, 4'h5));
        vecs.push_back(mk("subn_half",  0, 8'd0,   22'h100000, 0, 0, 0, 0, RNE, 16'h0200, 4'h0));
        vecs.push_back(mk("uf_rne",     0, 8'hF6,  22'h100000, 0, 0, 0, 0, RNE, 16'h0000, 4'h3));
        vecs.push_back(mk("uf_rp",      0, 8'hF6,  22'h100000, 0, 0, 0, 0, RP,  16'h0001, 4'h3));
        vecs.push_back(mk("nan_inv",    0, 8'd0,   22'h000000, 0, 1, 0, 1, RNE, 16'h7E00, 4'h8));
        vecs.push_back(mk("nan_over_inf", 1, 8'd0, 22'h000000, 0, 1, 1, 0, RNE, 16'h7E00, 4'h0));
        vecs.push_back(mk("inf_neg",    1, 8'd0,   22'h000000, 0, 0, 1, 0, RNE, 16'hFC00, 4'h0));
        vecs.push_back(mk("zero_neg",   1, 8'd20,  22'h000000, 0, 0, 0, 0, RP,  16'h8000, 4'h0));
        vecs.push_back(mk("lead_top",   0, 8'd15,  22'h200000, 0, 0, 0, 0, RNE, 16'h4000, 4'h0));
        vecs.push_back(mk("lead_low",   0, 8'd15,  22'h000001, 0, 0, 0, 0, RNE, 16'h0010, 4'h0));
        vecs.push_back(mk("min_norm",   0, 8'd0,   22'h1FFFFF, 0, 0, 0, 0, RNE, 16'h0400, 4'h1));
        vecs.push_back(mk("subn_rz",    0, 8'd0,   22'h1FFFFF, 0, 0, 0, 0, RZ,  16'h03FF, 4'h3));
        vecs.push_back(mk("renorm",     0, 8'd15,  22'h1FFFFF, 0, 0, 0, 0, RNE, 16'h4000, 4'h1));
        vecs.push_back(mk("rz_trunc",   0, 8'd15,  22'h1FFFFF, 0, 0, 0, 0, RZ,  16'h3FFF, 4'h1));
        vecs.push_back(mk("sticky_rp",  0, 8'd15,  22'h100000, 1, 0, 0, 0, RP,  16'h3C01, 4'h1));

        stall_v.push_back(mk("stall_a", 0, 8'd15, 22'h100000, 0, 0, 0, 0, RNE, 16'h3C00, 4'h0));
        stall_v.push_back(mk("stall_b", 0, 8'd15, 22'h100600, 0, 0, 0, 0, RNE, 16'h3C02, 4'h1));
        stall_v.push_back(mk("stall_c", 0, 8'd16, 22'h100000, 0, 0, 0, 0, RNE, 16'h4000, 4'h0));
        stall_v.push_back(mk("stall_d", 1, 8'd15, 22'h100000, 0, 0, 0, 0, RNE, 16'hBC00, 4'h0));

        bus.in_valid = 0; bus.Ss = 0; bus.Se = '0; bus.Sm = '0; bus.sticky = 0;
        bus.in_nan = 0; bus.in_inf = 0; bus.in_invalid = 0; bus.roundmode = 2'b01;
        bus.out_ready = 1;
        reset = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_flags", 32'(bus.flags), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, visible after the second following edge.
        drive(vecs[0]);
        @(negedge clk);
        check("latency_cycle1", 32'(bus.out_valid), 0);
        @(negedge clk);
        check("latency_cycle2", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        foreach (vecs[i]) drive(vecs[i]);
        drain();

        // Backpressure: both stages fill, input stalls, output holds.
        bus.out_ready = 0;
        fork
            begin
                foreach (stall_v[i]) drive(stall_v[i]);
            end
            begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    check("stall_in_ready", 32'(bus.in_ready), 0);
                    check("stall_out_valid", 32'(bus.out_valid), 1);
                    check("stall_result", 32'(bus.result), 32'h3C00);
                    check("stall_flags", 32'(bus.flags), 0);
                    if (k < 2) @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain();

        // Reset with two items in flight: neither may ever appear.
        bus.out_ready = 0;
        drive(vecs[1]);
        drive(vecs[2]);
        reset = 1;
        @(negedge clk);
        check("in_ready_during_reset", 32'(bus.in_ready), 0);
        @(negedge clk);
        check("out_valid_after_reset", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1 reset = 0;
        bus.out_ready = 1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flushed_items", 32'(seen), 0);
        @(posedge clk);
        #1;

        drive(vecs[3]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
